// File: rtl/nbit_bin_to_bcd_seq.sv
// rtl/nbit_bin_to_bcd_seq.sv - sequential shift-and-add-3 binary to N-digit BCD converter
// One bit per clock; out-of-range values flag ovf and keep the low N decimal digits.
module nbit_bin_to_bcd_seq #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   bin_in,
    output logic           busy,
    output logic           done,
    output logic [N*4-1:0] bcd_out,
    output logic           ovf
);
    localparam int DW = N * 4;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    bin_q, bin_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;

    logic [DW-1:0]   dig_adj;
    logic [DW+W-1:0] shifted;
    logic            accept;
    logic            last_iter;

    assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last_iter = (state_q == S_SHIFT) && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            dig_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            dig_q   <= dig_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Digits >= 5 are corrected before the shift so doubling carries into the next decade.
    always_comb begin
        dig_adj = '0;
        for (int i = 0; i < N; i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            else                         dig_adj[4*i +: 4] = dig_q[4*i +: 4];
        end
        shifted = {dig_adj, bin_q} << 1;
    end

    always_comb begin
        bin_d   = bin_q;
        dig_d   = dig_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        if (accept) begin
            bin_d   = bin_in;
            dig_d   = '0;
            carry_d = 1'b0;
            cnt_d   = CW'(W);
        end else if (state_q == S_SHIFT) begin
            bin_d   = shifted[W-1:0];
            dig_d   = shifted[DW+W-1:W];
            // A bit leaving the top digit means the value has reached 10^N.
            carry_d = carry_q | dig_adj[DW-1];
            cnt_d   = cnt_q - CW'(1);
            if (last_iter) begin
                bcd_d = shifted[DW+W-1:W];
                ovf_d = carry_q | dig_adj[DW-1];
            end
        end
    end

    always_comb begin
        busy    = (state_q == S_SHIFT);
        done    = (state_q == S_DONE);
        bcd_out = bcd_q;
        ovf     = ovf_q;
    end
endmodule
